// File: rtl/mem_seq_engine.sv
// mem_seq_engine: fill / copy / check sequencer on the
// shared single-port memory request bus.
module mem_seq_engine #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [MEM_AW-1:0] src_base,
  input  logic [MEM_AW-1:0] dst_base,
  input  logic [MEM_AW-1:0] src_stride,
  input  logic [MEM_AW-1:0] dst_stride,
  input  logic [CNT_W-1:0]  count,
  input  logic [MEM_DW-1:0] pattern,
  output logic              mem_req,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rdata_vld,
  input  logic [MEM_DW-1:0] mem_rdata,
  output logic              busy,
  output logic              ret,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [MEM_AW-1:0] first_err_addr
);

  localparam logic [1:0] FILL_INV = 2'd1;
  localparam logic [1:0] COPY     = 2'd2;
  localparam logic [1:0] CHECK    = 2'd3;

  typedef enum logic [2:0] {
    IDLE, RD, RWAIT, WR, DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]        mode_q;
  logic [MEM_AW-1:0] ss_q, ds_q;
  logic [CNT_W-1:0]  cnt_q, k;
  logic [MEM_AW-1:0] src_acc, dst_acc;
  logic [MEM_DW-1:0] patk;

  logic              last, advance, rsp;
  logic [MEM_AW-1:0] src_nx, dst_nx;
  logic [MEM_DW-1:0] patk_nx;

  function automatic logic [MEM_DW-1:0] fill_val(
    input logic [1:0]        m,
    input logic [MEM_DW-1:0] d
  );
    return (m == FILL_INV) ? ~d : d;
  endfunction

  assign last    = (k == cnt_q - 1'b1);
  assign src_nx  = src_acc + ss_q;
  assign dst_nx  = dst_acc + ds_q;
  assign patk_nx = patk + 1'b1;
  assign rsp     = (state == RWAIT) && mem_rdata_vld;
  assign advance = ((state == WR) && mem_gnt) ||
                   (rsp && (mode_q == CHECK));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state decode; abort wins over grant and read data
  always_comb begin
    state_nx = state;
    if (abort && (state != IDLE)) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: if (go) begin
          if (count == '0)  state_nx = DONE;
          else if (mode[1]) state_nx = RD;
          else              state_nx = WR;
        end
        WR: if (mem_gnt) begin
          if (last)                 state_nx = DONE;
          else if (mode_q == COPY)  state_nx = RD;
          else                      state_nx = WR;
        end
        RD: if (mem_gnt) state_nx = RWAIT;
        RWAIT: if (mem_rdata_vld) begin
          if (mode_q == COPY) state_nx = WR;
          else if (last)      state_nx = DONE;
          else                state_nx = RD;
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // handshake/status outputs straight from the state register
  always_comb begin
    mem_req = (state == RD) || (state == WR);
    busy    = (state != IDLE);
    ret     = (state == DONE);
  end

  // config latch, element accumulators and registered bus fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q         <= '0;
      ss_q           <= '0;
      ds_q           <= '0;
      cnt_q          <= '0;
      k              <= '0;
      src_acc        <= '0;
      dst_acc        <= '0;
      patk           <= '0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (state == IDLE) begin
      if (go) begin
        mode_q         <= mode;
        ss_q           <= src_stride;
        ds_q           <= dst_stride;
        cnt_q          <= count;
        k              <= '0;
        src_acc        <= src_base;
        dst_acc        <= dst_base;
        patk           <= pattern;
        err_cnt        <= '0;
        first_err_addr <= '0;
        if (count != '0) begin
          mem_write <= ~mode[1];
          mem_addr  <= mode[1] ? src_base : dst_base;
          if (!mode[1]) mem_wdata <= fill_val(mode, pattern);
        end
      end
    end else if (!abort) begin
      if (rsp && (mode_q == COPY)) begin
        mem_wdata <= mem_rdata;
        mem_addr  <= dst_acc;
        mem_write <= 1'b1;
      end
      if (rsp && (mode_q == CHECK) && (mem_rdata != patk)) begin
        if (err_cnt != '1)  err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0)  first_err_addr <= src_acc;
      end
      if (advance) begin
        k       <= k + 1'b1;
        src_acc <= src_nx;
        dst_acc <= dst_nx;
        patk    <= patk_nx;
        if (!last) begin
          if (!mode_q[1]) begin
            mem_addr  <= dst_nx;
            mem_wdata <= fill_val(mode_q, patk_nx);
            mem_write <= 1'b1;
          end else begin
            mem_addr  <= src_nx;
            mem_write <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/mem_seq_engine.md
Name: mem_seq_engine

Overview:
- Parametrised memory sequencing engine on the shared single-port memory request bus (mem_req/mem_write/mem_addr/mem_wdata, mem_rdata_vld/mem_rdata).
- Generalises the fixed "write ~(i+1) to base+i+1" fill loop to four modes: FILL_INC, FILL_INV, COPY, CHECK.
- Adds per-side strides, a configurable count, a grant handshake and an error report for CHECK.
- Started by a go level from the controlling sequencer; reports completion with a one-cycle ret pulse.

Parameters:
MEM_AW, 16, memory address width
MEM_DW, 32, memory data width
CNT_W, 16, width of count and internal index k
ERR_W, 8, width of saturating error counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
go  in  1  start request, sampled only in IDLE
abort  in  1  synchronous abort, effective in any non-IDLE state
mode  in  2  0=FILL_INC 1=FILL_INV 2=COPY 3=CHECK
src_base, dst_base  in  MEM_AW  first read / write address
src_stride, dst_stride  in  MEM_AW  address increment per element
count  in  CNT_W  number of elements N
pattern  in  MEM_DW  data seed
mem_req  out  1  request valid, held until mem_gnt
mem_write  out  1  1=write, 0=read; valid with mem_req
mem_addr  out  MEM_AW  request address
mem_wdata  out  MEM_DW  write data
mem_gnt  in  1  request accepted when mem_req & mem_gnt
mem_rdata_vld  in  1  read data valid
mem_rdata  in  MEM_DW  read data
busy  out  1  high from go acceptance until ret cycle inclusive
ret  out  1  one-cycle done pulse
err_cnt  out  ERR_W  CHECK mismatches, saturating at all-ones
first_err_addr  out  MEM_AW  src address of first mismatch; meaningful when err_cnt!=0

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; k=0.
- States: IDLE, RD, RWAIT, WR, DONE.
- IDLE, go=1 (cycle 0):
  - latch all config inputs; clear err_cnt and first_err_addr; k=0; busy=1 from cycle 1.
  - N=0: go to DONE.
  - N>0: FILL modes go to WR; COPY/CHECK go to RD.
  - First mem_req is asserted in cycle 1.
- Element k addressing, all arithmetic modulo 2^MEM_AW / 2^MEM_DW with silent wrap:
  - src address = src_base + k*src_stride; dst address = dst_base + k*dst_stride (running accumulators, no multiplier).
  - FILL_INC wdata = pattern + k.
  - FILL_INV wdata = ~(pattern + k).
- WR: mem_req=1, mem_write=1, address and data stable while mem_gnt=0. On mem_gnt, k advances:
  - if k+1==N go to DONE;
  - else FILL modes stay in WR (back-to-back, one write per granted cycle), COPY goes to RD.
- RD: mem_req=1, mem_write=0, src address held until mem_gnt, then RWAIT.
- RWAIT: mem_req=0. Accept the first mem_rdata_vld (earliest the cycle after grant):
  - COPY: capture mem_rdata as wdata, go to WR.
  - CHECK: compare with pattern+k. On mismatch, increment err_cnt (saturate); on the first mismatch, store the src address. Then advance k; go to DONE if k+1==N, else RD.
- mem_rdata_vld outside RWAIT is ignored. Only one read is ever outstanding.
- DONE: ret=1 and busy=1 for exactly one cycle; mem_req=0; next state IDLE; err_cnt holds until the next go.
- go while busy is ignored. go held high after DONE restarts the engine the cycle after ret.
- abort in a non-IDLE state: next cycle IDLE, mem_req=0, busy=0, no ret pulse; a pending read response is dropped. abort has priority over grant in the same cycle (that transfer still completes on the bus but k is not advanced).
- mem_addr/mem_wdata/mem_write are registered; they hold their last value when mem_req=0.
- Throughput with mem_gnt tied 1:
  - FILL: N writes in cycles 1..N, ret in cycle N+1.
  - COPY: 3 cycles per element plus read latency.

Test Plan:
1. Legacy fill: mode=1, dst_base=0x0101, dst_stride=1, pattern=1, N=4, gnt=1 -> writes 0x0101..0x0104 with data 0xFFFFFFFE, 0xFFFFFFFD, 0xFFFFFFFC, 0xFFFFFFFB in cycles 1-4; ret in cycle 5.
2. Backpressure: mode=0, pattern=0x10, dst_stride=4, N=3, gnt low on alternate cycles -> addr/data stable while ungranted; exactly 3 writes (data 0x10, 0x11, 0x12); one ret.
3. Copy: mode=2, src 0x0200 stride 1, dst 0x0300 stride 2, N=2, memory returns 0xAAAA/0xBBBB 2 cycles after grant -> writes (0x0300, 0xAAAA), (0x0302, 0xBBBB); stray rdata_vld in WR ignored.
4. Check: mode=3, pattern=0, N=4, data 0,1,7,9 -> err_cnt=2, first_err_addr=src_base+2; ERR_W=1 with 3 mismatches -> err_cnt=1 (saturated).
5. Edge cases: N=0 -> ret the cycle after go, no mem_req. dst_base=0xFFFF, stride=1, N=2 -> addresses 0xFFFF, 0x0000.
6. abort in RWAIT, then rst_n low mid-FILL -> mem_req=0 next cycle (abort) / immediately (reset); ret never pulses; a fresh go runs cleanly.
